// File: rtl/mem_data_ctrl_pkg.sv
// Shared constants for the data-side memory controller: access widths,
// FSM states and the IO window decode.
package mem_data_ctrl_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int ID_WIDTH      = 32;

  localparam logic [2:0] WIDTH_B = 3'b001;
  localparam logic [2:0] WIDTH_H = 3'b010;
  localparam logic [2:0] WIDTH_W = 3'b100;

  // Addresses whose [17:16] bits are 2'b11 target the IO write buffer.
  localparam int         IO_SEL_HI  = 17;
  localparam int         IO_SEL_LO  = 16;
  localparam logic [1:0] IO_SEL_VAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2
  } state_e;

  // Index of the final byte of an access (n-1); anything not byte/half is a word.
  function automatic logic [1:0] last_idx(input logic [2:0] width);
    case (width)
      WIDTH_B: last_idx = 2'd0;
      WIDTH_H: last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_data_ctrl_slot.sv
// Pending-request slot: captures a request pulse and holds it until the
// controller starts it. Outputs bypass the register so a request can start
// in the same cycle it arrives.
module mem_req_slot #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 cap_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic                 start_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  // Flush beats start beats capture: a pulse coinciding with a flush is dropped.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (start_i) begin
      valid_d = 1'b0;
    end else if (cap_i) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (rdy_in) begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = !flush_i && (valid_q || cap_i);
  assign payload_o = valid_q ? payload_q : payload_i;

endmodule

// File: rtl/mem_data_ctrl.sv
// Data-side memory controller: serialises ROB stores and load-buffer loads
// onto the byte-wide RAM port and returns one-cycle completion pulses.
//
// state   | meaning
// S_IDLE  | no access in flight; starts a pending store, else a pending load
// S_STORE | writing bytes; last_q set once the final byte is on the bus
// S_LOAD  | issuing addresses and collecting read bytes one cycle later
module mem_data_ctrl
  import mem_data_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_WIDTH,
  parameter int DATA_W = ID_WIDTH
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              rob_datactrl_en_in,
  input  logic [ADDR_W-1:0] rob_datactrl_addr_in,
  input  logic [2:0]        rob_datactrl_width_in,
  input  logic [DATA_W-1:0] rob_datactrl_data_in,
  output logic              datactrl_rob_en_out,
  input  logic              lbuffer_datactrl_en_in,
  input  logic [ADDR_W-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]        lbuffer_datactrl_width_in,
  input  logic              lbuffer_datactrl_signed_in,
  output logic              datactrl_lbuffer_en_out,
  output logic [DATA_W-1:0] datactrl_lbuffer_data_out,
  input  logic              rob_rst_in,
  input  logic              io_buffer_full_in,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic [7:0]        mem_dout_out,
  output logic              mem_wr_out,
  input  logic [7:0]        mem_din_in
);

  localparam int ST_PL_W = ADDR_W + 3 + DATA_W;
  localparam int LD_PL_W = ADDR_W + 3 + 1;

  logic               st_valid, ld_valid;
  logic [ST_PL_W-1:0] st_pl;
  logic [LD_PL_W-1:0] ld_pl;
  logic               st_start, ld_start;

  logic [ADDR_W-1:0]  st_pl_addr, ld_pl_addr;
  logic [2:0]         st_pl_width, ld_pl_width;
  logic [DATA_W-1:0]  st_pl_data;
  logic               ld_pl_signed;

  state_e             state_q;
  logic [1:0]         cnt_q;
  logic               last_q;
  logic               av_q, dv_q;
  logic [1:0]         cap_q;
  logic [ADDR_W-1:0]  act_addr_q;
  logic [2:0]         act_width_q;
  logic [DATA_W-1:0]  act_data_q;
  logic               act_signed_q;
  logic [DATA_W-1:0]  buf_q;
  logic [ADDR_W-1:0]  a_q;
  logic [7:0]         dout_q;
  logic               wr_q;
  logic               st_done_q, ld_done_q;
  logic [DATA_W-1:0]  ld_data_q;

  mem_req_slot #(.PAYLOAD_W(ST_PL_W)) u_st_slot (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rdy_in    (rdy_in),
    .cap_i     (rob_datactrl_en_in),
    .payload_i ({rob_datactrl_addr_in, rob_datactrl_width_in, rob_datactrl_data_in}),
    .start_i   (st_start),
    .flush_i   (1'b0),
    .valid_o   (st_valid),
    .payload_o (st_pl)
  );

  mem_req_slot #(.PAYLOAD_W(LD_PL_W)) u_ld_slot (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rdy_in    (rdy_in),
    .cap_i     (lbuffer_datactrl_en_in),
    .payload_i ({lbuffer_datactrl_addr_in, lbuffer_datactrl_width_in, lbuffer_datactrl_signed_in}),
    .start_i   (ld_start),
    .flush_i   (rob_rst_in),
    .valid_o   (ld_valid),
    .payload_o (ld_pl)
  );

  assign {st_pl_addr, st_pl_width, st_pl_data}   = st_pl;
  assign {ld_pl_addr, ld_pl_width, ld_pl_signed} = ld_pl;

  // Committed stores are older than any load, so they always win in IDLE.
  assign st_start = (state_q == S_IDLE) && st_valid;
  assign ld_start = (state_q == S_IDLE) && !st_valid && ld_valid;

  // Store byte issue, shared between the IDLE start edge and the STORE state.
  logic [ADDR_W-1:0] sx_addr;
  logic [DATA_W-1:0] sx_data;
  logic [2:0]        sx_width;
  logic [1:0]        sx_k;
  logic              sx_en, sx_stall, sx_last;
  logic [7:0]        sx_byte;

  always_comb begin
    sx_addr  = act_addr_q;
    sx_data  = act_data_q;
    sx_width = act_width_q;
    sx_k     = cnt_q;
    if (st_start) begin
      sx_addr  = st_pl_addr;
      sx_data  = st_pl_data;
      sx_width = st_pl_width;
      sx_k     = 2'd0;
    end
  end

  assign sx_en    = st_start || ((state_q == S_STORE) && !last_q);
  assign sx_stall = io_buffer_full_in && (sx_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
  assign sx_last  = (sx_k == last_idx(sx_width));
  assign sx_byte  = sx_data[{sx_k, 3'b000} +: 8];

  // Load result: collected bytes plus the one arriving on mem_din_in now.
  logic [DATA_W-1:0] ld_raw, ld_ext;

  always_comb begin
    ld_raw = buf_q;
    ld_raw[{cap_q, 3'b000} +: 8] = mem_din_in;
  end

  always_comb begin
    case (act_width_q)
      WIDTH_B: ld_ext = {{(DATA_W-8){act_signed_q & ld_raw[7]}}, ld_raw[7:0]};
      WIDTH_H: ld_ext = {{(DATA_W-16){act_signed_q & ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      last_q       <= 1'b0;
      av_q         <= 1'b0;
      dv_q         <= 1'b0;
      cap_q        <= 2'd0;
      act_addr_q   <= '0;
      act_width_q  <= 3'b000;
      act_data_q   <= '0;
      act_signed_q <= 1'b0;
      buf_q        <= '0;
      a_q          <= '0;
      dout_q       <= 8'h00;
      wr_q         <= 1'b0;
      st_done_q    <= 1'b0;
      ld_done_q    <= 1'b0;
      ld_data_q    <= '0;
    end else if (rdy_in) begin
      st_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wr_q <= 1'b0;
          if (st_start) begin
            state_q     <= S_STORE;
            act_addr_q  <= st_pl_addr;
            act_width_q <= st_pl_width;
            act_data_q  <= st_pl_data;
          end else if (ld_start) begin
            state_q      <= S_LOAD;
            act_addr_q   <= ld_pl_addr;
            act_width_q  <= ld_pl_width;
            act_signed_q <= ld_pl_signed;
            a_q          <= ld_pl_addr;
            if (last_idx(ld_pl_width) == 2'd0) begin
              last_q <= 1'b1;
              cnt_q  <= 2'd0;
            end else begin
              last_q <= 1'b0;
              cnt_q  <= 2'd1;
            end
            av_q  <= 1'b1;
            dv_q  <= 1'b0;
            cap_q <= 2'd0;
            buf_q <= '0;
          end
        end
        S_STORE: begin
          if (last_q) begin
            st_done_q <= 1'b1;
            wr_q      <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= 2'd0;
            state_q   <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (rob_rst_in) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
            cnt_q   <= 2'd0;
            av_q    <= 1'b0;
            dv_q    <= 1'b0;
            cap_q   <= 2'd0;
          end else begin
            // av_q: address on the bus now; dv_q: its read byte is on mem_din_in.
            av_q <= !last_q;
            dv_q <= av_q;
            if (!last_q) begin
              a_q <= act_addr_q + ADDR_W'(cnt_q);
              if (cnt_q == last_idx(act_width_q)) begin
                last_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end
            if (dv_q) begin
              buf_q <= ld_raw;
              if (cap_q == last_idx(act_width_q)) begin
                ld_data_q <= ld_ext;
                ld_done_q <= 1'b1;
                state_q   <= S_IDLE;
                last_q    <= 1'b0;
                cnt_q     <= 2'd0;
                av_q      <= 1'b0;
                dv_q      <= 1'b0;
                cap_q     <= 2'd0;
              end else begin
                cap_q <= cap_q + 2'd1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (sx_en) begin
        if (sx_stall) begin
          wr_q  <= 1'b0;
          cnt_q <= sx_k;
        end else begin
          a_q    <= sx_addr + ADDR_W'(sx_k);
          dout_q <= sx_byte;
          wr_q   <= 1'b1;
          if (sx_last) begin
            last_q <= 1'b1;
          end else begin
            cnt_q <= sx_k + 2'd1;
          end
        end
      end
    end
  end

  assign mem_a_out                 = a_q;
  assign mem_dout_out              = dout_q;
  assign mem_wr_out                = wr_q & rdy_in;
  assign datactrl_rob_en_out       = st_done_q;
  assign datactrl_lbuffer_en_out   = ld_done_q;
  assign datactrl_lbuffer_data_out = ld_data_q;

endmodule
